// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage and the main controller:
// opcodes, fetch FSM state encoding and instruction field positions.
package instr_fetch_pkg;

  localparam int INSTR_W = 32;

  localparam logic [5:0] ADD   = 6'h00;
  localparam logic [5:0] ADDI  = 6'h08;
  localparam logic [5:0] LOAD  = 6'h23;
  localparam logic [5:0] STORE = 6'h2B;

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_HOLD = 1'b1
  } fetch_state_e;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  // Instruction words are 4 bytes, so a legal target has its two low bits clear.
  function automatic logic isWordAligned(input logic [1:0] lowBits);
    return lowBits == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter with reset / redirect / sequential-increment selection.
// Redirect wins over increment; both are qualified by the fetch FSM.
module pc_reg
  import instr_fetch_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_loadPc,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pcPlus4;

  // Natural-width add wraps modulo 2^ADDR_W.
  assign w_pcPlus4 = r_pc + ADDR_W'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_loadPc;
    end else if (i_advance) begin
      r_pc <= w_pcPlus4;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding-request fetch FSM, instruction
// register with field decode, accepted-instruction counter and misalign flag.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0]  RESET_PC = 32'h0000_0000,
  parameter int unsigned  ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              instr_ready,
  output logic              instr_valid,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm16,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              misalign_err,
  output logic [15:0]       fetch_count
);

  fetch_state_e        r_state;
  logic                r_imemReq;
  logic [INSTR_W-1:0]  r_ir;
  logic [ADDR_W-1:0]   r_instrPc;
  logic                r_instrValid;
  logic                r_misalignErr;
  logic [15:0]         r_fetchCount;

  logic [ADDR_W-1:0]   w_pc;
  logic                w_redirAligned;
  logic                w_redirMisaligned;
  logic                w_accept;

  assign w_redirAligned    = redirect_valid &&  isWordAligned(redirect_pc[1:0]);
  assign w_redirMisaligned = redirect_valid && !isWordAligned(redirect_pc[1:0]);
  assign w_accept          = (r_state == ST_REQ) && imem_ack && !w_redirAligned;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC[ADDR_W-1:0])
  ) u_pcReg (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_redirAligned),
    .i_loadPc  (redirect_pc),
    .i_advance (w_accept),
    .o_pc      (w_pc)
  );

  // An aligned redirect preempts both the ack and the downstream handshake,
  // so a squashed instruction is never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_REQ;
      r_imemReq     <= 1'b1;
      r_ir          <= '0;
      r_instrPc     <= '0;
      r_instrValid  <= 1'b0;
      r_misalignErr <= 1'b0;
      r_fetchCount  <= '0;
    end else begin
      if (w_redirMisaligned) begin
        r_misalignErr <= 1'b1;
      end
      if (w_redirAligned) begin
        r_state      <= ST_REQ;
        r_imemReq    <= 1'b1;
        r_instrValid <= 1'b0;
      end else begin
        case (r_state)
          ST_REQ: begin
            if (imem_ack) begin
              r_ir         <= imem_rdata;
              r_instrPc    <= w_pc;
              r_instrValid <= 1'b1;
              r_imemReq    <= 1'b0;
              r_state      <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (instr_ready) begin
              r_instrValid <= 1'b0;
              r_fetchCount <= r_fetchCount + 16'd1;
              r_imemReq    <= 1'b1;
              r_state      <= ST_REQ;
            end
          end
        endcase
      end
    end
  end

  assign imem_req     = r_imemReq;
  assign imem_addr    = w_pc;
  assign instr_valid  = r_instrValid;
  assign instr_pc     = r_instrPc;
  assign misalign_err = r_misalignErr;
  assign fetch_count  = r_fetchCount;

  assign opcode = r_ir[OPCODE_MSB:OPCODE_LSB];
  assign rs     = r_ir[RS_MSB:RS_LSB];
  assign rt     = r_ir[RT_MSB:RT_LSB];
  assign rd     = r_ir[RD_MSB:RD_LSB];
  assign imm16  = r_ir[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a transaction-level model is stepped every
// clock and compared against the DUT, plus hand-computed literal checks.
module tb_instr_fetch;

  localparam int unsigned ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;
  logic [31:0] instr_pc;
  logic        misalign_err;
  logic [15:0] fetch_count;

  int vectorCount = 0;
  int missCount   = 0;

  // Model state: "holding" means a fetched word is waiting for decode.
  logic [31:0] mPc;
  logic [31:0] mIr;
  logic [31:0] mIpc;
  bit          mHolding;
  bit          mMis;
  int          mAccepted;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC (RESET_PC),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_ready    (instr_ready),
    .instr_valid    (instr_valid),
    .opcode         (opcode),
    .rs             (rs),
    .rt             (rt),
    .rd             (rd),
    .imm16          (imm16),
    .instr_pc       (instr_pc),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock of the fetch rules, applied to the inputs the DUT saw at this edge.
  task automatic modelStep();
    bit goodRedirect;
    if (rst) begin
      mPc = RESET_PC; mIr = 0; mIpc = 0; mHolding = 0; mMis = 0; mAccepted = 0;
      return;
    end
    goodRedirect = redirect_valid && (redirect_pc % 4 == 0);
    if (redirect_valid && !goodRedirect) mMis = 1;
    if (goodRedirect) begin
      mPc = redirect_pc;
      mHolding = 0;
    end else if (!mHolding && imem_ack) begin
      mIr = imem_rdata;
      mIpc = mPc;
      mPc = mPc + 4;
      mHolding = 1;
    end else if (mHolding && instr_ready) begin
      mHolding = 0;
      mAccepted++;
    end
  endtask

  task automatic compareAll();
    checkOutput("imem_req",     32'(imem_req),     32'(!mHolding));
    checkOutput("imem_addr",    imem_addr,         mPc);
    checkOutput("instr_valid",  32'(instr_valid),  32'(mHolding));
    checkOutput("opcode",       32'(opcode),       mIr / (2**26));
    checkOutput("rs",           32'(rs),           (mIr / (2**21)) % 32);
    checkOutput("rt",           32'(rt),           (mIr / (2**16)) % 32);
    checkOutput("rd",           32'(rd),           (mIr / (2**11)) % 32);
    checkOutput("imm16",        32'(imm16),        mIr % 65536);
    checkOutput("instr_pc",     instr_pc,          mIpc);
    checkOutput("misalign_err", 32'(misalign_err), 32'(mMis));
    checkOutput("fetch_count",  32'(fetch_count),  32'(mAccepted % 65536));
  endtask

  // Inputs change on the falling edge; outputs are compared on the next falling edge.
  task automatic applyStimulus(input logic r, input logic ack, input logic [31:0] data,
                               input logic rv, input logic [31:0] rpc, input logic rdy);
    rst = r; imem_ack = ack; imem_rdata = data;
    redirect_valid = rv; redirect_pc = rpc; instr_ready = rdy;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mPc = RESET_PC; mIr = 0; mIpc = 0; mHolding = 0; mMis = 0; mAccepted = 0;

    // Reset, including reset winning over ack/redirect/ready together.
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(1, 1, 32'hDEAD_BEEF, 1, 32'h80, 1);
    checkOutput("rst_addr",  imem_addr,          RESET_PC);
    checkOutput("rst_req",   32'(imem_req),      32'd1);
    checkOutput("rst_valid", 32'(instr_valid),   32'd0);
    checkOutput("rst_count", 32'(fetch_count),   32'd0);

    // Zero-wait fetch of ADDI, then accept.
    applyStimulus(0, 1, 32'h2008_0005, 0, 32'h0, 0);
    checkOutput("addi_op",    32'(opcode),      32'h08);
    checkOutput("addi_rt",    32'(rt),          32'd8);
    checkOutput("addi_imm",   32'(imm16),       32'h0005);
    checkOutput("addi_ipc",   instr_pc,         32'h0);
    checkOutput("addi_next",  imem_addr,        32'h4);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("addi_count", 32'(fetch_count), 32'd1);
    checkOutput("addi_req",   32'(imem_req),    32'd1);

    // Ack delayed three cycles.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 32'h1234_5678, 0, 32'h0, 1);
      checkOutput("wait_req",  32'(imem_req), 32'd1);
      checkOutput("wait_addr", imem_addr,     32'h4);
    end
    applyStimulus(0, 1, 32'h8C22_0010, 0, 32'h0, 0);
    checkOutput("load_valid", 32'(instr_valid), 32'd1);
    checkOutput("load_ipc",   instr_pc,         32'h4);

    // Decode stalls for five cycles.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 32'hFFFF_0000, 0, 32'h0, 0);
    end
    checkOutput("stall_req", 32'(imem_req), 32'd0);
    checkOutput("stall_op",  32'(opcode),   32'h23);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);

    // Redirect coinciding with ack drops the data.
    applyStimulus(0, 1, 32'hFFFF_FFFF, 1, 32'h40, 0);
    checkOutput("redir_valid", 32'(instr_valid), 32'd0);
    checkOutput("redir_addr",  imem_addr,        32'h40);
    checkOutput("redir_count", 32'(fetch_count), 32'd2);
    checkOutput("redir_op",    32'(opcode),      32'h23);

    // Ready is ignored while requesting; ADD word decodes rd.
    applyStimulus(0, 1, 32'h0043_2020, 0, 32'h0, 1);
    checkOutput("add_rd",  32'(rd),           32'd4);
    checkOutput("add_ipc", instr_pc,          32'h40);
    checkOutput("add_cnt", 32'(fetch_count),  32'd2);

    // Redirect in HOLD with ready: no count.
    applyStimulus(0, 0, 32'h0, 1, 32'h100, 1);
    checkOutput("hold_redir_cnt",  32'(fetch_count), 32'd2);
    checkOutput("hold_redir_addr", imem_addr,        32'h100);

    // Misaligned redirect is ignored but latches the error.
    applyStimulus(0, 1, 32'hAC85_0008, 1, 32'h42, 0);
    checkOutput("mis_err",  32'(misalign_err), 32'd1);
    checkOutput("mis_ipc",  instr_pc,          32'h100);
    checkOutput("mis_addr", imem_addr,         32'h104);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("mis_sticky", 32'(misalign_err), 32'd1);

    // PC wraps past the top of the address space.
    applyStimulus(0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0);
    applyStimulus(0, 1, 32'h2008_FFFF, 0, 32'h0, 0);
    checkOutput("wrap_addr", imem_addr, 32'h0);
    checkOutput("wrap_ipc",  instr_pc,  32'hFFFF_FFFC);

    // Counter wrap: preload 16'hFFFF while holding, then accept one.
    force dut.r_fetchCount = 16'hFFFF;
    #1;
    release dut.r_fetchCount;
    mAccepted = 16'hFFFF;
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("count_wrap", 32'(fetch_count), 32'd0);

    // Reset mid-request, then ack in the first post-reset cycle.
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(1, 1, 32'h5555_AAAA, 1, 32'h200, 1);
    checkOutput("midrst_addr", imem_addr,          RESET_PC);
    checkOutput("midrst_err",  32'(misalign_err),  32'd0);
    checkOutput("midrst_op",   32'(opcode),        32'h0);
    checkOutput("midrst_ipc",  instr_pc,           32'h0);
    applyStimulus(0, 1, 32'h2008_0005, 0, 32'h0, 0);
    checkOutput("post_ipc",   instr_pc,         RESET_PC);
    checkOutput("post_valid", 32'(instr_valid), 32'd1);
    checkOutput("post_addr",  imem_addr,        RESET_PC + 32'd4);
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter ADDR_W, default 32, the PC and memory address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port imem_req, output, 1, instruction-memory read request.
REQ-006 SHALL have port imem_addr, output, ADDR_W, read address, always equal to pc.
REQ-007 SHALL have port imem_ack, input, 1, memory read complete this cycle.
REQ-008 SHALL have port imem_rdata, input, 32, instruction word, valid when imem_ack=1.
REQ-009 SHALL have port redirect_valid, input, 1, branch/jump PC override request.
REQ-010 SHALL have port redirect_pc, input, ADDR_W, override target.
REQ-011 SHALL have port instr_ready, input, 1, decode stage accepts the held instruction.
REQ-012 SHALL have port instr_valid, output, 1, instruction register holds a valid word.
REQ-013 SHALL have ports opcode, 6 bits [31:26]; rs, 5 bits [25:21]; rt, 5 bits [20:16]; rd, 5 bits [15:11]; imm16, 16 bits [15:0]. All are outputs and are sliced from the instruction register; opcode feeds the main controller.
REQ-014 SHALL have port instr_pc, output, ADDR_W, the address the held instruction was fetched from.
REQ-015 SHALL have port misalign_err, output, 1, sticky misaligned-redirect flag.
REQ-016 SHALL have port fetch_count, output, 16, count of instructions accepted downstream.

Function
REQ-017 SHALL implement an FSM with two states: REQ and HOLD.
REQ-018 In REQ, the block SHALL drive imem_req=1 and hold imem_req high until imem_ack.
REQ-019 In REQ with imem_ack=1 and no redirect, the block SHALL:
- load the IR with imem_rdata;
- set instr_pc to pc;
- set pc to pc+4, wrapping modulo 2^ADDR_W;
- set instr_valid=1;
- go to HOLD.
REQ-020 In HOLD, the block SHALL drive imem_req=0 and keep the IR, instr_pc and instr_valid=1 stable.
REQ-021 In HOLD with instr_ready=1, the block SHALL:
- clear instr_valid;
- increment fetch_count, wrapping 16'hFFFF to 0;
- go to REQ, so the next request issues the following cycle.
REQ-022 In REQ, instr_ready SHALL be ignored.
REQ-023 Minimum issue interval SHALL be 2 cycles per instruction with a zero-wait memory.
REQ-024 A redirect_valid with redirect_pc[1:0]==0 SHALL take priority over all other events in any state:
- pc is set to redirect_pc;
- instr_valid is cleared;
- next state is REQ;
- fetch_count is not incremented, even if instr_ready=1 the same cycle.
REQ-025 A redirect coinciding with imem_ack in REQ SHALL discard imem_rdata and leave the IR unchanged.
REQ-026 A redirect with redirect_pc[1:0]!=0 SHALL be ignored entirely and SHALL set misalign_err=1, which holds until reset.
REQ-027 imem_addr SHALL be combinational from pc; all other outputs SHALL be registered or FSM-decoded.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL set:
- pc=RESET_PC;
- state=REQ;
- IR=0;
- instr_pc=0;
- instr_valid=0;
- misalign_err=0;
- fetch_count=0.
REQ-029 Reset SHALL override redirect, ack and ready in the same cycle.
REQ-030 Reset asserted mid-fetch SHALL abandon the outstanding request; an imem_ack in the first post-reset cycle is accepted as the response to RESET_PC.
REQ-031 imem_req SHALL read 1 in the first cycle after rst deasserts.

Structure
REQ-032 The shared package SHALL hold:
- opcode constants ADD=6'h00, ADDI=6'h08, LOAD=6'h23, STORE=6'h2B, shared with the controller;
- the FSM state encoding;
- the instruction field bit positions.
REQ-033 The PC register with its increment/redirect/reset mux SHALL be a sub-module named pc_reg; the FSM, IR and counters stay in instr_fetch.

Verification
REQ-034 Reset, then zero-wait ack with rdata=32'h2008_0005 and ready=1: opcode=6'h08, rt=8, imm16=16'h0005, instr_pc=0, next imem_addr=4, fetch_count=1.
REQ-035 Ack delayed 3 cycles: imem_req stays high and imem_addr is stable for 3 cycles; instr_valid rises the cycle after the ack.
REQ-036 Ready held 0 for 5 cycles in HOLD: the IR, instr_valid=1 and imem_req=0 are stable; no new request is issued.
REQ-037 redirect_valid=1, redirect_pc=32'h40 coincident with imem_ack: the data is dropped, instr_valid=0, the next imem_addr is 32'h40, and fetch_count is unchanged.
REQ-038 redirect_pc=32'h42: the redirect is ignored, misalign_err=1 persists, and the pc sequence continues.
REQ-039 Set fetch_count to 16'hFFFF, then accept one more instruction: fetch_count=0. Then assert rst mid-REQ: all outputs return to their reset values and imem_addr=RESET_PC.
